// File: rtl/microprocessor_core_if.sv
// ----------------------------------------------------------------------------
// microprocessor_core_if
// Groups the fetch and debug write-back bus of the single-cycle core.
//
//   instruction  environment -> core : instruction word at the current pc
//   pc           core -> environment : current program counter
//   wb_en        core -> environment : a register write happens at next edge
//   wb_addr      core -> environment : destination register (rd)
//   wb_data      core -> environment : value being written
//   alu_result   core -> environment : current ALU output
//
// Modports: master = core side, slave = environment / instruction memory side.
// ----------------------------------------------------------------------------
interface microprocessor_core_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DIR_WIDTH  = 5
);
    logic [31:0]           instruction;
    logic [DATA_WIDTH-1:0] pc;
    logic                  wb_en;
    logic [DIR_WIDTH-1:0]  wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [DATA_WIDTH-1:0] alu_result;

    modport master (
        input  instruction,
        output pc,
        output wb_en,
        output wb_addr,
        output wb_data,
        output alu_result
    );

    modport slave (
        output instruction,
        input  pc,
        input  wb_en,
        input  wb_addr,
        input  wb_data,
        input  alu_result
    );
endinterface

// File: rtl/microprocessor_core.sv
// ----------------------------------------------------------------------------
// microprocessor_core
// Single-cycle RV32I-subset core (ADDI, ADD, BEQ, JAL). One instruction is
// consumed per rising edge; decode, register read, execute and next-pc
// selection are all combinational from the current pc and instruction.
//
// Ports:
//   clk     rising-edge clock
//   arst_n  asynchronous reset, ACTIVE-HIGH despite its name
//   bus     microprocessor_core_if.master
//           (instruction in; pc, wb_en, wb_addr, wb_data, alu_result out)
// ----------------------------------------------------------------------------
module microprocessor_core #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DIR_WIDTH  = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = {DATA_WIDTH{1'b0}}
) (
    input  logic                        clk,
    input  logic                        arst_n,
    microprocessor_core_if.master       bus
);

    localparam int NUM_REGS = 1 << DIR_WIDTH;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    // ------------------------------------------------------------------
    // Immediate helpers: each builds the sign-extended immediate for one
    // instruction format.
    // ------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] imm_i(input logic [31:0] inst);
        return {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] imm_b(input logic [31:0] inst);
        return {{(DATA_WIDTH-13){inst[31]}}, inst[31], inst[7], inst[30:25],
                inst[11:8], 1'b0};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] imm_j(input logic [31:0] inst);
        return {{(DATA_WIDTH-21){inst[31]}}, inst[31], inst[19:12], inst[20],
                inst[30:21], 1'b0};
    endfunction

    // State
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // Instruction fields
    logic [6:0]           w_opcode;
    logic [2:0]           w_funct3;
    logic [6:0]           w_funct7;
    logic [DIR_WIDTH-1:0] w_rd;
    logic [DIR_WIDTH-1:0] w_rs1;
    logic [DIR_WIDTH-1:0] w_rs2;

    // Control
    logic                  w_reg_write;
    logic                  w_use_imm;
    logic                  w_alu_sub;
    logic                  w_alu_pc;
    logic                  w_is_branch;
    logic                  w_is_jal;
    logic [DATA_WIDTH-1:0] w_imm;

    // Datapath
    logic [DATA_WIDTH-1:0] w_rs1_data;
    logic [DATA_WIDTH-1:0] w_rs2_data;
    logic [DATA_WIDTH-1:0] w_alu_a;
    logic [DATA_WIDTH-1:0] w_alu_b;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic                  w_zero;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_branch_target;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic [DATA_WIDTH-1:0] w_wb_data;
    logic                  w_wb_en;

    assign w_opcode = bus.instruction[6:0];
    assign w_rd     = bus.instruction[11:7];
    assign w_funct3 = bus.instruction[14:12];
    assign w_rs1    = bus.instruction[19:15];
    assign w_rs2    = bus.instruction[24:20];
    assign w_funct7 = bus.instruction[31:25];

    // Control unit: unsupported encodings fall through as a NOP (no write, pc+4).
    always_comb begin
        w_reg_write = 1'b0;
        w_use_imm   = 1'b0;
        w_alu_sub   = 1'b0;
        w_alu_pc    = 1'b0;
        w_is_branch = 1'b0;
        w_is_jal    = 1'b0;
        w_imm       = {DATA_WIDTH{1'b0}};
        case (w_opcode)
            OP_ADDI: begin
                w_imm     = imm_i(bus.instruction);
                w_use_imm = 1'b1;
                if (w_funct3 == 3'b000) begin
                    w_reg_write = 1'b1;
                end else begin
                    w_reg_write = 1'b0;
                end
            end
            OP_ADD: begin
                if ((w_funct3 == 3'b000) && (w_funct7 == 7'b0000000)) begin
                    w_reg_write = 1'b1;
                end else begin
                    w_reg_write = 1'b0;
                end
            end
            OP_BEQ: begin
                // Equality is decided by the zero flag of rs1 - rs2.
                w_imm       = imm_b(bus.instruction);
                w_alu_sub   = 1'b1;
                w_is_branch = 1'b1;
            end
            OP_JAL: begin
                // The ALU forms the jump target; the link value is pc+4.
                w_imm       = imm_j(bus.instruction);
                w_use_imm   = 1'b1;
                w_alu_pc    = 1'b1;
                w_is_jal    = 1'b1;
                w_reg_write = 1'b1;
            end
            default: begin
                w_reg_write = 1'b0;
            end
        endcase
    end

    // Register file read ports: x0 is hard-wired to zero. Reads see the old
    // value of a register being written this cycle because the write lands
    // only on the next edge.
    always_comb begin
        if (w_rs1 == {DIR_WIDTH{1'b0}}) begin
            w_rs1_data = {DATA_WIDTH{1'b0}};
        end else begin
            w_rs1_data = r_regs[w_rs1];
        end
        if (w_rs2 == {DIR_WIDTH{1'b0}}) begin
            w_rs2_data = {DATA_WIDTH{1'b0}};
        end else begin
            w_rs2_data = r_regs[w_rs2];
        end
    end

    // ALU: add or subtract, modulo 2^DATA_WIDTH, zero flag for BEQ.
    always_comb begin
        w_alu_a = w_alu_pc  ? r_pc  : w_rs1_data;
        w_alu_b = w_use_imm ? w_imm : w_rs2_data;
        if (w_alu_sub) begin
            w_alu_result = w_alu_a - w_alu_b;
        end else begin
            w_alu_result = w_alu_a + w_alu_b;
        end
        w_zero = (w_alu_result == {DATA_WIDTH{1'b0}});
    end

    // Next-pc mux; a separate adder forms the branch target because the ALU
    // is busy with the comparison. Misaligned targets are taken as computed.
    always_comb begin
        w_pc_plus4      = r_pc + PC_STEP;
        w_branch_target = r_pc + w_imm;
        if (w_is_jal) begin
            w_next_pc = w_alu_result;
        end else if (w_is_branch && w_zero) begin
            w_next_pc = w_branch_target;
        end else begin
            w_next_pc = w_pc_plus4;
        end
    end

    // Write-back select and enable; writes to x0 and writes during reset are
    // suppressed so the debug port never reports them.
    always_comb begin
        if (w_is_jal) begin
            w_wb_data = w_pc_plus4;
        end else begin
            w_wb_data = w_alu_result;
        end
        w_wb_en = w_reg_write && (w_rd != {DIR_WIDTH{1'b0}}) && !arst_n;
    end

    // Program counter register.
    always_ff @(posedge clk or posedge arst_n) begin
        if (arst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // Register file write port; the whole file clears on reset.
    always_ff @(posedge clk or posedge arst_n) begin
        if (arst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (w_wb_en) begin
            r_regs[w_rd] <= w_wb_data;
        end
    end

    assign bus.pc         = r_pc;
    assign bus.wb_en      = w_wb_en;
    assign bus.wb_addr    = w_rd;
    assign bus.wb_data    = w_wb_data;
    assign bus.alu_result = w_alu_result;

endmodule

// File: tb/tb_microprocessor_core.sv
module tb_microprocessor_core;

    logic clk    = 1'b0;
    logic arst_n = 1'b1;
    always #5 clk = ~clk;

    microprocessor_core_if bus ();

    microprocessor_core dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state and per-instruction predictions
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_alu;
    logic        e_alu_ok;
    logic [31:0] e_npc;
    logic [31:0] probe_v;

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [12:0] o);
        return {o[12], o[10:5], rs2, rs1, 3'b000, o[4:1], o[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] o);
        return {o[20], o[10:1], o[11], o[19:12], rd, 7'b1101111};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pc = 32'h0;
    endtask

    // Architectural effect of one instruction, from the ISA rules
    task automatic predict(input logic [31:0] ins);
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] a, b, imm_i, imm_b, imm_j;
        logic [12:0] b13;
        logic [20:0] j21;
        op  = ins[6:0];
        rd  = ins[11:7];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        a   = m_regs[rs1];
        b   = m_regs[rs2];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        b13   = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_b = {{19{b13[12]}}, b13};
        j21   = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        imm_j = {{11{j21[20]}}, j21};
        e_en = 1'b0; e_addr = rd; e_data = 32'h0; e_alu = 32'h0; e_alu_ok = 1'b0;
        e_npc = m_pc + 32'd4;
        if (op == 7'b0010011 && ins[14:12] == 3'b000) begin
            e_alu = a + imm_i; e_alu_ok = 1'b1; e_data = e_alu; e_en = (rd != 5'd0);
        end else if (op == 7'b0110011 && ins[14:12] == 3'b000 && ins[31:25] == 7'b0) begin
            e_alu = a + b; e_alu_ok = 1'b1; e_data = e_alu; e_en = (rd != 5'd0);
        end else if (op == 7'b1100011) begin
            e_alu = a - b; e_alu_ok = 1'b1;
            if (a == b) e_npc = m_pc + imm_b;
        end else if (op == 7'b1101111) begin
            e_data = m_pc + 32'd4; e_en = (rd != 5'd0); e_npc = m_pc + imm_j;
        end
    endtask

    // Drive an instruction (called just after a rising edge) and let it settle
    task automatic issue(input logic [31:0] ins);
        bus.instruction = ins;
        predict(ins);
        #1;
    endtask

    // Commit the predicted effect and cross the next rising edge
    task automatic tick();
        if (e_en) m_regs[e_addr] = e_data;
        m_pc = e_npc;
        @(posedge clk);
        #1;
    endtask

    // Read a register through the ALU without changing state (ADDI x0,xk,0)
    task automatic probe(input logic [4:0] k, output logic [31:0] v);
        issue(enc_addi(5'd0, k, 12'h000));
        v = bus.alu_result;
        tick();
    endtask

    task automatic test_reset();
        arst_n = 1'b1;
        bus.instruction = enc_addi(5'd1, 5'd0, 12'd5);
        #1;
        n_checks++; if (bus.pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); else n_pass++;
        n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL reset_wb_en: got %b want 0", bus.wb_en); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.pc !== 32'h0) $display("FAIL reset_pc_hold: got %h want %h", bus.pc, 32'h0); else n_pass++;
        arst_n = 1'b0;
        model_reset();
    endtask

    task automatic test_addi();
        issue(enc_addi(5'd1, 5'd0, 12'd5));
        n_checks++; if (bus.wb_en !== 1'b1) $display("FAIL addi_wb_en: got %b want 1", bus.wb_en); else n_pass++;
        n_checks++; if (bus.wb_addr !== 5'd1) $display("FAIL addi_wb_addr: got %0d want 1", bus.wb_addr); else n_pass++;
        n_checks++; if (bus.wb_data !== 32'd5) $display("FAIL addi_wb_data: got %h want 5", bus.wb_data); else n_pass++;
        n_checks++; if (bus.pc !== 32'h0) $display("FAIL addi_pc0: got %h want 0", bus.pc); else n_pass++;
        tick();
        n_checks++; if (bus.pc !== 32'h4) $display("FAIL addi_pc4: got %h want 4", bus.pc); else n_pass++;
    endtask

    task automatic test_add();
        issue(enc_addi(5'd2, 5'd0, 12'hFFF));
        n_checks++; if (bus.wb_data !== 32'hFFFF_FFFF) $display("FAIL addi_neg: got %h want ffffffff", bus.wb_data); else n_pass++;
        tick();
        issue(enc_add(5'd3, 5'd1, 5'd2));
        n_checks++; if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd3) $display("FAIL add_wb: got en=%b addr=%0d want en=1 addr=3", bus.wb_en, bus.wb_addr); else n_pass++;
        n_checks++; if (bus.wb_data !== 32'd4) $display("FAIL add_data: got %h want 4", bus.wb_data); else n_pass++;
        tick();
        issue(enc_addi(5'd4, 5'd0, 12'd1));
        tick();
        issue(enc_add(5'd5, 5'd2, 5'd4));
        n_checks++; if (bus.wb_data !== 32'h0 || bus.alu_result !== 32'h0) $display("FAIL add_wrap: got data=%h alu=%h want 0", bus.wb_data, bus.alu_result); else n_pass++;
        tick();
        n_checks++; if (bus.pc !== 32'h14) $display("FAIL add_pc: got %h want 14", bus.pc); else n_pass++;
    endtask

    task automatic test_branch();
        issue(enc_jal(5'd0, 21'h1FFFFC));
        tick();
        n_checks++; if (bus.pc !== 32'h10) $display("FAIL jal_back4: got %h want 10", bus.pc); else n_pass++;
        issue(enc_beq(5'd1, 5'd1, 13'd8));
        n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL beq_wb_en: got %b want 0", bus.wb_en); else n_pass++;
        tick();
        n_checks++; if (bus.pc !== 32'h18) $display("FAIL beq_taken: got %h want 18", bus.pc); else n_pass++;
        issue(enc_jal(5'd0, 21'h1FFFF8));
        tick();
        issue(enc_beq(5'd1, 5'd2, 13'd8));
        n_checks++; if (bus.alu_result !== 32'd6) $display("FAIL beq_alu: got %h want 6", bus.alu_result); else n_pass++;
        tick();
        n_checks++; if (bus.pc !== 32'h14) $display("FAIL beq_not_taken: got %h want 14", bus.pc); else n_pass++;
        issue(enc_jal(5'd0, 21'h1FFFFC));
        tick();
        issue(enc_beq(5'd0, 5'd0, 13'h1FFC));
        tick();
        n_checks++; if (bus.pc !== 32'h0C) $display("FAIL beq_negative: got %h want c", bus.pc); else n_pass++;
    endtask

    task automatic test_jal();
        issue(enc_jal(5'd0, 21'h14));
        tick();
        issue(enc_jal(5'd1, 21'd16));
        n_checks++; if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd1) $display("FAIL jal_wb: got en=%b addr=%0d want en=1 addr=1", bus.wb_en, bus.wb_addr); else n_pass++;
        n_checks++; if (bus.wb_data !== 32'h24) $display("FAIL jal_link: got %h want 24", bus.wb_data); else n_pass++;
        tick();
        n_checks++; if (bus.pc !== 32'h30) $display("FAIL jal_target: got %h want 30", bus.pc); else n_pass++;
        issue(enc_jal(5'd0, 21'h1FFFF0));
        tick();
        issue(enc_jal(5'd0, 21'h1FFFF8));
        n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL jal_x0_wb_en: got %b want 0", bus.wb_en); else n_pass++;
        tick();
        n_checks++; if (bus.pc !== 32'h18) $display("FAIL jal_x0_pc: got %h want 18", bus.pc); else n_pass++;
        probe(5'd1, probe_v);
        n_checks++; if (probe_v !== 32'h24) $display("FAIL jal_x1_value: got %h want 24", probe_v); else n_pass++;
    endtask

    task automatic test_x0_nop();
        logic [31:0] pc_before;
        issue(enc_addi(5'd0, 5'd0, 12'd7));
        n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL addi_x0_wb_en: got %b want 0", bus.wb_en); else n_pass++;
        tick();
        issue(enc_add(5'd4, 5'd0, 5'd0));
        n_checks++; if (bus.wb_en !== 1'b1 || bus.wb_data !== 32'h0) $display("FAIL add_x0: got en=%b data=%h want en=1 data=0", bus.wb_en, bus.wb_data); else n_pass++;
        tick();
        probe(5'd0, probe_v);
        n_checks++; if (probe_v !== 32'h0) $display("FAIL x0_zero: got %h want 0", probe_v); else n_pass++;
        pc_before = m_pc;
        issue(32'hDEAD_BE80);
        n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL nop_wb_en: got %b want 0", bus.wb_en); else n_pass++;
        tick();
        n_checks++; if (bus.pc !== pc_before + 32'd4) $display("FAIL nop_pc: got %h want %h", bus.pc, pc_before + 32'd4); else n_pass++;
        issue(32'h0010_9093);   // funct3=001 under the ADDI opcode
        n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL bad_funct3_wb_en: got %b want 0", bus.wb_en); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        issue(enc_addi(5'd7, 5'd0, 12'd9));
        arst_n = 1'b1;
        #1;
        n_checks++; if (bus.pc !== 32'h0) $display("FAIL midreset_pc: got %h want 0", bus.pc); else n_pass++;
        n_checks++; if (bus.wb_en !== 1'b0) $display("FAIL midreset_wb_en: got %b want 0", bus.wb_en); else n_pass++;
        bus.instruction = enc_addi(5'd0, 5'd1, 12'h000);
        #1;
        n_checks++; if (bus.alu_result !== 32'h0) $display("FAIL midreset_x1: got %h want 0", bus.alu_result); else n_pass++;
        @(posedge clk); #1;
        arst_n = 1'b0;
        model_reset();
        probe(5'd7, probe_v);
        n_checks++; if (probe_v !== 32'h0) $display("FAIL midreset_abandoned: got %h want 0", probe_v); else n_pass++;
        probe(5'd3, probe_v);
        n_checks++; if (probe_v !== 32'h0) $display("FAIL midreset_x3: got %h want 0", probe_v); else n_pass++;
        n_checks++; if (bus.pc !== 32'h8) $display("FAIL midreset_restart_pc: got %h want 8", bus.pc); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [4:0]  rd, rs1, rs2;
        int          v;
        for (int i = 0; i < 40; i++) begin
            rd  = 5'($urandom_range(0, 31));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            v   = int'($urandom_range(0, 127)) - 64;
            case (i % 4)
                0: ins = enc_addi(rd, rs1, 12'($urandom));
                1: ins = enc_add(rd, rs1, rs2);
                2: begin
                    if ($urandom_range(0, 1) == 1) rs2 = rs1;
                    ins = enc_beq(rs1, rs2, 13'(v * 4));
                end
                default: ins = enc_jal(rd, 21'(v * 4));
            endcase
            issue(ins);
            n_checks++; if (bus.pc !== m_pc) $display("FAIL rand_pc[%0d]: got %h want %h", i, bus.pc, m_pc); else n_pass++;
            n_checks++; if (bus.wb_en !== e_en) $display("FAIL rand_wb_en[%0d]: got %b want %b", i, bus.wb_en, e_en); else n_pass++;
            if (e_en) begin
                n_checks++; if (bus.wb_addr !== e_addr || bus.wb_data !== e_data) $display("FAIL rand_wb[%0d]: got x%0d=%h want x%0d=%h", i, bus.wb_addr, bus.wb_data, e_addr, e_data); else n_pass++;
            end
            if (e_alu_ok) begin
                n_checks++; if (bus.alu_result !== e_alu) $display("FAIL rand_alu[%0d]: got %h want %h", i, bus.alu_result, e_alu); else n_pass++;
            end
            tick();
        end
        n_checks++; if (bus.pc !== m_pc) $display("FAIL rand_final_pc: got %h want %h", bus.pc, m_pc); else n_pass++;
        for (int k = 1; k < 32; k++) begin
            probe(5'(k), probe_v);
            n_checks++; if (probe_v !== m_regs[k]) $display("FAIL rand_reg[x%0d]: got %h want %h", k, probe_v, m_regs[k]); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instruction = 32'h0;
        model_reset();
        #2;
        test_reset();
        test_addi();
        test_add();
        test_branch();
        test_jal();
        test_x0_nop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/microprocessor_core.md
# microprocessor_core

Single-cycle RV32I-subset processor core executing ADDI, ADD, BEQ and JAL; it is the top-level datapath of the Fibonacci microprocessor. Each clock it consumes one 32-bit instruction word supplied on an input port, addressed by the exported program counter. Internally it contains the PC, a 32-entry register file, an immediate generator, an ALU, a control unit and the next-PC mux. A debug write-back port exposes every architectural register update.

## Interface
- DATA_WIDTH, 32, register/ALU/PC width
- DIR_WIDTH, 5, register-address width (32 registers)
- RESET_PC, 32'h0000_0000, PC value while and after reset

- clk  in  1  rising-edge clock
- arst_n  in  1  asynchronous reset, active-high (1 = reset asserted despite the name); one clock, reset asynchronous active-high
- instruction  in  32  instruction word for the current PC (combinational fetch by the environment)
- pc  out  DATA_WIDTH  current program counter
- wb_en  out  1  register write occurring at next rising edge
- wb_addr  out  DIR_WIDTH  destination register (rd)
- wb_data  out  DATA_WIDTH  value written
- alu_result  out  DATA_WIDTH  current ALU output

## Operation
- Decode on instruction[6:0]: 0010011 ADDI, 0110011 ADD, 1100011 BEQ, 1101111 JAL. ADDI/ADD additionally require funct3=000 (ADD also funct7=0000000); any other encoding is a NOP: no write, PC+4.
- Fields: rd=[11:7], rs1=[19:15], rs2=[24:20].
- Immediates, sign-extended to 32 bits:
  - I = {inst[31:20]}.
  - B = {inst[31],inst[7],inst[30:25],inst[11:8],1'b0} (13 bits).
  - J = {inst[31],inst[19:12],inst[20],inst[30:21],1'b0} (21 bits).
- ADDI: rd ← rs1 + I. ADD: rd ← rs1 + rs2. Both: PC ← PC+4.
- BEQ: ALU computes rs1 − rs2; if zero, PC ← PC + B, else PC+4. No register write.
- JAL: rd ← PC+4; PC ← PC + J.
- Arithmetic is modulo 2^32; overflow is ignored, with no flags other than the internal zero flag.
- Register file: two combinational read ports, one synchronous write port.
  - x0 reads 0 always; writes to x0 are discarded and wb_en is 0 for rd=0.
  - Read of a register written in the same cycle returns the old value.
- Misaligned branch/jump targets are not trapped; PC takes the computed value.

## Timing
- Single cycle: decode, read, execute and next-PC are combinational from instruction/pc; PC and rd update on the same rising edge.
- pc, wb_* and alu_result are combinational from current state and instruction.
- Reset assertion (asynchronous):
  - pc = RESET_PC, all registers = 0 immediately.
  - wb_en = 0 while in reset.
  - An instruction in flight is abandoned, with no write.
- After deassertion, the first rising edge executes the instruction at RESET_PC.
- The environment must change instruction only after a rising edge and keep it stable before the next one.

## Test plan
- Reset then ADDI x1,x0,5 → wb_en=1, wb_addr=1, wb_data=5; pc 0→4.
- ADDI x2,x0,-1 (imm 0xFFF), then ADD x3,x1,x2 with x1=5 → x2=0xFFFF_FFFF, x3=4; ADD of 0xFFFF_FFFF+1 wraps to 0.
- BEQ x1,x1,+8 at pc=0x10 → pc=0x18, wb_en=0; BEQ x1,x2,+8 with x1≠x2 → pc=0x14; negative offset −4 at 0x10 → 0x0C.
- JAL x1,+16 at pc=0x20 → x1=0x24, pc=0x30; JAL x0,−8 → no write, pc=0x18.
- ADDI x0,x0,7 then ADD x4,x0,x0 → x0 stays 0, x4=0; unknown opcode 0000000 → NOP, pc+4.
- Assert arst_n mid-program between edges → pc=0 and registers=0 immediately; random 10× each of ADDI/ADD/BEQ/JAL checked against a reference model.
